// File: rtl/memlcd_scan_ctrl.sv
// Scan-timing controller for parallel-RGB memory LCDs: VCOM/VA/VB generation and the
// gate/source waveforms, fed by a valid/ready pixel stream, with line-window partial updates.
module memlcd_scan_ctrl #(
    parameter  int H_PIX      = 240,
    parameter  int V_LINES    = 240,
    parameter  int BPC        = 1,
    parameter  int BCK_DIV    = 4,
    parameter  int GEN_HALVES = 2,
    parameter  int VCOM_DIV   = 833333,
    localparam int LW         = (V_LINES > 1) ? $clog2(V_LINES) : 1,
    localparam int PW         = 6 * BPC
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_start,
    input  logic [LW-1:0] i_first_line,
    input  logic [LW-1:0] i_last_line,
    input  logic          i_abort,
    input  logic [PW-1:0] i_pix_data,
    input  logic          i_pix_valid,
    output logic          o_pix_ready,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [LW-1:0] o_line,
    output logic          o_va,
    output logic          o_vb,
    output logic          o_vcom,
    output logic          o_gsp,
    output logic          o_gck,
    output logic          o_gen,
    output logic          o_bsp,
    output logic          o_bck,
    output logic [PW-1:0] o_rgb
);

    localparam int WORDS   = H_PIX / 2;
    localparam int WW      = $clog2(WORDS + 1);
    localparam int GEN_CYC = GEN_HALVES * BCK_DIV;
    localparam int CMAX    = (GEN_CYC > BCK_DIV) ? GEN_CYC : BCK_DIV;
    localparam int CW      = $clog2(CMAX + 1);
    localparam int VW      = $clog2(VCOM_DIV + 1);

    localparam logic [LW:0]   VL        = (LW+1)'(V_LINES);
    localparam logic [LW-1:0] LAST_LINE = LW'(V_LINES - 1);
    localparam logic [WW-1:0] LAST_WORD = WW'(WORDS - 1);
    localparam logic [CW-1:0] HALF_END  = CW'(BCK_DIV - 1);
    localparam logic [CW-1:0] GEN_END   = CW'(GEN_CYC - 1);
    localparam logic [VW-1:0] VCOM_END  = VW'(VCOM_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_GSP, S_FETCH, S_HOLD, S_GEN, S_GCK, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] word_q, word_d;
    logic [LW-1:0] line_q, line_d;
    logic [LW-1:0] first_q, first_d;
    logic [LW-1:0] last_q, last_d;
    logic [LW-1:0] next_line;
    logic [PW-1:0] rgb_q, rgb_d;
    logic          gsp_q, gsp_d, gck_q, gck_d, gen_q, gen_d;
    logic          bsp_q, bsp_d, bck_q, bck_d;
    logic          ready_q, ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [VW-1:0] vcnt_q;
    logic          vcom_q, va_q, vb_q;

    function automatic logic in_window(input logic [LW-1:0] l, input logic [LW-1:0] f,
                                       input logic [LW-1:0] t);
        return (l >= f) && (l <= t);
    endfunction

    // Common drive runs freely; neither the FSM nor abort touches it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            vcnt_q <= '0;
            vcom_q <= 1'b0;
            va_q   <= 1'b1;
            vb_q   <= 1'b0;
        end else if (vcnt_q == VCOM_END) begin
            vcnt_q <= '0;
            vcom_q <= ~vcom_q;
            va_q   <= vcom_q;
            vb_q   <= ~vcom_q;
        end else begin
            vcnt_q <= vcnt_q + VW'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        line_d    = line_q;
        first_d   = first_q;
        last_d    = last_q;
        rgb_d     = rgb_q;
        gsp_d     = gsp_q;
        gck_d     = gck_q;
        gen_d     = gen_q;
        bsp_d     = bsp_q;
        bck_d     = bck_q;
        err_d     = 1'b0;
        next_line = line_q + LW'(1);

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    if ((i_first_line <= i_last_line) && ({1'b0, i_last_line} < VL)) begin
                        first_d = i_first_line;
                        last_d  = i_last_line;
                        line_d  = '0;
                        cnt_d   = '0;
                        gsp_d   = 1'b1;
                        state_d = S_GSP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_GSP: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == HALF_END) begin
                    cnt_d = '0;
                    if (in_window('0, first_q, last_q)) begin
                        word_d  = '0;
                        state_d = S_FETCH;
                    end else begin
                        gck_d   = ~gck_q;
                        state_d = S_GCK;
                    end
                end
            end
            S_FETCH: begin
                if (i_pix_valid) begin
                    rgb_d = i_pix_data;
                    if (word_q == '0) bsp_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == HALF_END) begin
                    cnt_d = '0;
                    bck_d = ~bck_q;
                    bsp_d = 1'b0;
                    if (word_q == LAST_WORD) begin
                        gen_d   = 1'b1;
                        state_d = S_GEN;
                    end else begin
                        word_d  = word_q + WW'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_GEN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == GEN_END) begin
                    cnt_d   = '0;
                    gen_d   = 1'b0;
                    gck_d   = ~gck_q;
                    state_d = S_GCK;
                end
            end
            S_GCK: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == HALF_END) begin
                    cnt_d = '0;
                    if (line_q == '0) gsp_d = 1'b0;
                    if (line_q == LAST_LINE) begin
                        state_d = S_DONE;
                    end else begin
                        line_d = next_line;
                        if (in_window(next_line, first_q, last_q)) begin
                            word_d  = '0;
                            state_d = S_FETCH;
                        end else begin
                            // Skipped lines still clock the gate shift register.
                            gck_d = ~gck_q;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort drops the active strobes but leaves the clock levels where they are.
        if (i_abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            gsp_d   = 1'b0;
            gen_d   = 1'b0;
            bsp_d   = 1'b0;
            gck_d   = gck_q;
            bck_d   = bck_q;
        end

        ready_d = (state_d == S_FETCH);
        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            line_q  <= '0;
            first_q <= '0;
            last_q  <= '0;
            rgb_q   <= '0;
            gsp_q   <= 1'b0;
            gck_q   <= 1'b0;
            gen_q   <= 1'b0;
            bsp_q   <= 1'b0;
            bck_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            line_q  <= line_d;
            first_q <= first_d;
            last_q  <= last_d;
            rgb_q   <= rgb_d;
            gsp_q   <= gsp_d;
            gck_q   <= gck_d;
            gen_q   <= gen_d;
            bsp_q   <= bsp_d;
            bck_q   <= bck_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign o_pix_ready = ready_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign o_line      = line_q;
    assign o_va        = va_q;
    assign o_vb        = vb_q;
    assign o_vcom      = vcom_q;
    assign o_gsp       = gsp_q;
    assign o_gck       = gck_q;
    assign o_gen       = gen_q;
    assign o_bsp       = bsp_q;
    assign o_bck       = bck_q;
    assign o_rgb       = rgb_q;

endmodule

// File: doc/memlcd_scan_ctrl.md
# memlcd_scan_ctrl

Parametrised successor to the memory-LCD driver's timing and controller path for parallel-RGB memory LCDs. It generates VCOM/VA/VB and the full gate/source scan waveforms (GSP, GCK, GEN, BSP, BCK, RGB) for any panel geometry. It adds three things: a valid/ready pixel stream in place of the FIFO rinc/rempty pair, partial-frame updates over a programmable line window, and abort/error handling. It sits between the pixel FIFO (or any streaming source) and the panel pins.

## Interface
Parameters:
- H_PIX, 240: pixels per line; must be a multiple of 4. Two pixels are transferred per BCK half-period.
- V_LINES, 240: gate lines per frame.
- BPC, 1: bits per colour channel. Pixel word width is PW = 6*BPC.
- BCK_DIV, 4: i_clk cycles a data word is held before BCK toggles. Also defines one "half" of gate timing. Must be ≥1.
- GEN_HALVES, 2: length of the GEN pulse, in halves.
- VCOM_DIV, 833333: i_clk cycles per VCOM half period (60 Hz at 100 MHz).
- LW = $clog2(V_LINES): width of line indices (derived).

Ports:
- i_clk, in, 1: system clock.
- i_reset_n, in, 1: reset, asynchronous, active-low.
- i_start, in, 1: frame request; sampled only in IDLE.
- i_first_line, in, LW: first line of the update window; latched on i_start.
- i_last_line, in, LW: last line of the update window (inclusive); latched on i_start.
- i_abort, in, 1: terminate the current frame.
- i_pix_data, in, PW: two pixels, ordered {R1,R2,G1,G2,B1,B2}.
- i_pix_valid, in, 1: pixel word valid.
- o_pix_ready, out, 1: controller accepts a word.
- o_busy, out, 1: FSM not in IDLE.
- o_done, out, 1: one-cycle pulse when a frame completes.
- o_err, out, 1: one-cycle pulse when i_start carries an illegal window.
- o_line, out, LW: current gate line.
- o_va, o_vb, o_vcom, out, 1 each: panel common drive.
- o_gsp, o_gck, o_gen, o_bsp, o_bck, out, 1 each: gate and source timing.
- o_rgb, out, PW: registered pixel data.

## Operation
- **Reset:** all outputs are registered and are 0 under reset, except o_va, which is 1.
- **VCOM:** a free-running counter independent of the FSM. o_vcom toggles every VCOM_DIV cycles; o_va = ~o_vcom; o_vb = o_vcom. i_abort does not affect VCOM.
- **FSM states:** IDLE, GSP, FETCH, HOLD, GEN, GCK, DONE.
- **IDLE:**
  - On i_start with first ≤ last and last < V_LINES: latch the window, set line=0, and go to GSP.
  - On i_start with first > last or last ≥ V_LINES: pulse o_err and remain in IDLE.
- **GSP:** o_gsp=1 for one half, then go to FETCH if line 0 is in the window, otherwise to GCK.
- **FETCH:**
  - o_pix_ready=1 until i_pix_valid is seen.
  - In the handshake cycle: o_rgb <= i_pix_data, and go to HOLD.
  - On the first word of a line, o_bsp is set in the handshake cycle.
- **HOLD:**
  - Lasts BCK_DIV cycles.
  - On the last cycle: o_bck toggles, o_bsp clears.
  - Then go to FETCH if words remain, otherwise to GEN.
- **Words per line:** H_PIX/2. Because this count is even, o_bck ends every line at 0.
- **GEN:** o_gen=1 for GEN_HALVES halves, then go to GCK.
- **GCK:**
  - Lasts one half. o_gck toggles on entry.
  - o_gsp clears on leaving the GCK of line 0.
  - After the GCK of line V_LINES-1, go to DONE.
  - Otherwise line++, then go to FETCH if the new line is in the window, else stay in GCK.
- **Out-of-window lines:** get a GCK half only. They have no BCK, BSP or GEN activity and perform no handshakes.
- **DONE:** o_done=1 for one cycle with o_busy=0, then go to IDLE.
- **o_busy:** 1 in every state except IDLE and DONE.
- **i_abort:** in any non-IDLE state, the next state is IDLE. o_gsp, o_gen, o_bsp and o_pix_ready clear; o_gck and o_bck hold their level; no o_done is produced. i_abort has priority over i_start.
- **i_start while busy:** ignored.
- **Mid-frame reset:** immediate return to reset values.

## Timing
- One half = BCK_DIV cycles.
- Word slot with i_pix_valid held high: 1 + BCK_DIV cycles.
- Each cycle of i_pix_valid=0 in FETCH extends the slot by one cycle. o_rgb, o_bck and the counters hold during the stall.
- Frame length in busy cycles:
  - BCK_DIV, for the GSP state, plus
  - per in-window line: (H_PIX/2)(BCK_DIV+1) + GEN_HALVES·BCK_DIV + BCK_DIV, plus
  - per out-of-window line: BCK_DIV, plus
  - stall cycles.
- o_rgb changes only in handshake cycles. Each word is stable BCK_DIV cycles before its BCK edge.
- o_done is asserted in the cycle after the final GCK half.

## Test plan
- **Reset:** assert i_reset_n=0 mid-line → all outputs 0 except o_va=1, asynchronously. After release: o_busy=0, no o_done.
- **VCOM:** VCOM_DIV=5 → o_vcom toggles every 5 cycles; o_va is always its inverse and o_vb always equals it.
- **Full frame:** H_PIX=8, V_LINES=4, BCK_DIV=2, GEN_HALVES=1, window 0..3, valid held high → 16 handshakes; 4 BSP pulses and 4 GEN pulses; 16 BCK toggles; 4 GCK toggles; o_busy high for exactly 66 cycles, then a single o_done.
- **Partial frame:** same parameters, window 1..2 → 8 handshakes; 2 GEN pulses, on lines 1 and 2 only; 4 GCK toggles; o_busy high for 2+32+2+2=38 cycles.
- **Stall:** drop i_pix_valid for 10 cycles during word 2 of line 1 → o_pix_ready stays 1; o_bck and o_rgb hold; o_busy extends to 76 cycles.
- **Errors and abort:**
  - i_start with first=3, last=1 → o_err pulses once and o_busy stays 0.
  - i_abort during GEN → o_gen=0 and IDLE on the next cycle, no o_done.
  - A following legal i_start completes normally.
